// File: rtl/dsp_div.sv
// dsp_div: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle. Divide-by-zero and signed overflow bypass the
// iteration loop. The result is registered and announced by a one-cycle done.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          request, sampled only while idle
//   op             00=DIV 01=DIVU 10=REM 11=REMU
//   left_operand   dividend
//   right_operand  divisor
//   busy           high from the cycle after acceptance through the done cycle
//   done           one-cycle pulse, div_res valid
//   div_res        quotient or remainder, held until the next done
module dsp_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] left_operand,
  input  logic [WIDTH-1:0] right_operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] div_res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(WIDTH-1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             fix_ph_q;     // FIX runs two steps: negate, then select/register
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q, res_q;
  logic             neg_quo_q, neg_rem_q, sel_rem_q;

  // Operand conditioning at acceptance
  logic             signed_op, a_neg, b_neg, div0, ovf;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & left_operand[WIDTH-1];
  assign b_neg     = signed_op & right_operand[WIDTH-1];
  assign a_abs     = a_neg ? (~left_operand + 1'b1)  : left_operand;
  assign b_abs     = b_neg ? (~right_operand + 1'b1) : right_operand;
  assign div0      = (right_operand == '0);
  assign ovf       = signed_op & (left_operand == MIN_NEG) & (right_operand == ALL_ONES);

  // Restoring step. The shifted partial remainder can reach WIDTH+1 bits, so
  // the trial subtraction carries one extra bit to hold the sign.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;

  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign trial_ok = ~trial[WIDTH+1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (div0 | ovf) ? S_FIX : S_CALC;
      S_CALC: if (cnt_q == LAST_IT) state_d = S_FIX;
      S_FIX:  if (fix_ph_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      fix_ph_q  <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          cnt_q     <= '0;
          fix_ph_q  <= 1'b0;
          sel_rem_q <= op[1];
          dvs_q     <= b_abs;
          if (div0) begin
            quo_q     <= ALL_ONES;
            rem_q     <= left_operand;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
          end else if (ovf) begin
            quo_q     <= MIN_NEG;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
          end else begin
            quo_q     <= a_abs;     // dividend shifts out of quo as quotient shifts in
            rem_q     <= '0;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          quo_q <= {quo_q[WIDTH-2:0], trial_ok};
          rem_q <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        end
        S_FIX: begin
          fix_ph_q <= 1'b1;
          if (!fix_ph_q) begin
            if (neg_quo_q) quo_q <= ~quo_q + 1'b1;
            if (neg_rem_q) rem_q <= ~rem_q + 1'b1;
          end else begin
            res_q <= sel_rem_q ? rem_q : quo_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign div_res = res_q;

endmodule
